// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from ID/EX/MEM and stall/flush controls back to the pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rd;
    logic             ex_MemRead;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rd, ex_MemRead, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, memwb_flush, mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rd, ex_MemRead, ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, memwb_flush, mem_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, taken-branch and data-memory-wait hazards,
// with a memory-wait timeout halt and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             halt, freeze, load_use, live;
    logic [4:0]       en;
    logic [2:0]       fl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // The RUN->MEMWAIT cycle is wait cycle 0, so the first MEMWAIT cycle holds 1.
    always_comb begin
        halt     = state_q == HALT;
        freeze   = !halt && hz.mem_req && !hz.mem_ready;
        load_use = hz.ex_MemRead && hz.ex_rd != 5'd0 &&
                   (hz.ex_rd == hz.id_rs || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
        live     = rst_n && !halt;
        state_d  = state_q;
        wait_d   = wait_q;
        if (state_q == RUN && freeze) begin
            state_d = MEMWAIT;
            wait_d  = 16'd1;
        end else if (state_q == MEMWAIT) begin
            state_d = !freeze ? RUN : (wait_q == LAST_WAIT ? HALT : MEMWAIT);
            wait_d  = !freeze ? 16'd0 : wait_q + 16'd1;
        end
        err_d   = err_q || state_d == HALT;
        stall_d = (!halt && (freeze || (load_use && !hz.ex_branch_taken)) && !(&stall_q))
                  ? stall_q + 1'b1 : stall_q;
        flush_d = (hz.ex_branch_taken && !freeze && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
        en      = (!live || freeze) ? 5'b00000 :
                  hz.ex_branch_taken ? 5'b11111 :
                  load_use ? 5'b00111 : 5'b11111;
        fl      = !live ? 3'b000 :
                  freeze ? 3'b001 :
                  hz.ex_branch_taken ? 3'b110 :
                  load_use ? 3'b010 : 3'b000;
    end

    assign {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = en;
    assign {hz.ifid_flush, hz.idex_flush, hz.memwb_flush}               = fl;
    assign hz.mem_err      = err_q;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios for the hazard sequencer with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [4:0] en;
    logic [2:0] fl;

    pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();
    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

    always #5 clk = ~clk;

    assign en = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en};
    assign fl = {hz.ifid_flush, hz.idex_flush, hz.memwb_flush};

    task automatic idle();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.ex_rd = 0;
        hz.ex_MemRead = 0; hz.ex_branch_taken = 0; hz.mem_req = 0; hz.mem_ready = 0;
    endtask

    task automatic set_load_use();
        hz.ex_MemRead = 1; hz.ex_rd = 5; hz.id_rs = 5;
    endtask

    task automatic chk_out(input string name, input logic [4:0] exp_en, input logic [2:0] exp_fl);
        checks++;
        if (en !== exp_en || fl !== exp_fl) begin
            failures++;
            $display("FAIL %s: en=%b fl=%b, required en=%b fl=%b", name, en, fl, exp_en, exp_fl);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [3:0] exp_st, input logic [3:0] exp_fc,
                           input logic exp_err);
        checks++;
        if (hz.stall_cycles !== exp_st || hz.flush_count !== exp_fc || hz.mem_err !== exp_err) begin
            failures++;
            $display("FAIL %s: stall=%0d flush=%0d err=%b, required stall=%0d flush=%0d err=%b",
                     name, hz.stall_cycles, hz.flush_count, hz.mem_err, exp_st, exp_fc, exp_err);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        hz.id_rs = 3;
        #1;
        chk_out("reset_out", 5'b00000, 3'b000);
        chk_cnt("reset_cnt", 0, 0, 0);
        set_load_use();
        #1;
        chk_out("reset_out_hazard", 5'b00000, 3'b000);
        @(negedge clk);
        idle();
        rst_n = 1;
        #1;
        chk_out("first_enable", 5'b11111, 3'b000);
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); set_load_use(); #1;
        chk_out("lu_rs_out", 5'b00111, 3'b010);
        @(posedge clk); #1;
        chk_cnt("lu_rs_cnt", 1, 0, 0);
        @(negedge clk); hz.ex_rd = 0; hz.id_rs = 0; #1;
        chk_out("lu_r0_out", 5'b11111, 3'b000);
        @(posedge clk); #1;
        chk_cnt("lu_r0_cnt", 1, 0, 0);
        @(negedge clk); hz.ex_rd = 7; hz.id_rs = 3; hz.id_rt = 7; hz.id_uses_rt = 1; #1;
        chk_out("lu_rt_out", 5'b00111, 3'b010);
        @(posedge clk); #1;
        chk_cnt("lu_rt_cnt", 2, 0, 0);
        @(negedge clk); hz.id_uses_rt = 0; #1;
        chk_out("lu_rt_unused_out", 5'b11111, 3'b000);
        @(posedge clk); #1;
        chk_cnt("lu_rt_unused_cnt", 2, 0, 0);
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk); set_load_use(); hz.ex_branch_taken = 1; #1;
        chk_out("br_over_lu_out", 5'b11111, 3'b110);
        @(posedge clk); #1;
        chk_cnt("br_over_lu_cnt", 0, 1, 0);
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); hz.mem_req = 1; hz.mem_ready = 0; #1;
            chk_out($sformatf("mw_freeze%0d", i), 5'b00000, 3'b001);
            @(posedge clk);
        end
        @(negedge clk); hz.mem_ready = 1; #1;
        chk_out("mw_ready_out", 5'b11111, 3'b000);
        @(posedge clk); #1;
        chk_cnt("mw_cnt", 3, 0, 0);
        @(negedge clk); #1;
        chk_out("mw_zero_wait_out", 5'b11111, 3'b000);
        @(posedge clk); #1;
        chk_cnt("mw_zero_wait_cnt", 3, 0, 0);
        @(negedge clk); hz.mem_ready = 0; hz.ex_branch_taken = 1; set_load_use(); #1;
        chk_out("freeze_holds_br", 5'b00000, 3'b001);
        @(posedge clk); #1;
        chk_cnt("freeze_holds_br_cnt", 4, 0, 0);
        @(negedge clk); hz.mem_req = 0; #1;
        chk_out("req_drop_br", 5'b11111, 3'b110);
        @(posedge clk); #1;
        chk_cnt("req_drop_cnt", 4, 1, 0);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); hz.mem_req = 1; hz.mem_ready = 0; #1;
            chk_out($sformatf("to_wait%0d", i), 5'b00000, 3'b001);
            @(posedge clk); #1;
            chk_cnt($sformatf("to_wait%0d_cnt", i), 4'(i + 1), 0, i == 3);
        end
        chk_out("to_halt_out", 5'b00000, 3'b000);
        @(negedge clk); hz.mem_ready = 1; set_load_use(); #1;
        chk_out("to_halt_ready", 5'b00000, 3'b000);
        @(posedge clk); #1;
        chk_cnt("to_halt_sticky", 4, 0, 1);
        @(negedge clk); idle(); #2;
        rst_n = 0; #1;
        chk_cnt("to_reset_clear", 0, 0, 0);
        @(negedge clk); rst_n = 1; #1;
        chk_out("to_back_to_run", 5'b11111, 3'b000);
        @(negedge clk); hz.mem_req = 1; #1;
        chk_out("to_run_freeze", 5'b00000, 3'b001);
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) begin
            @(negedge clk); hz.mem_req = 1; hz.mem_ready = 0;
            @(posedge clk);
        end
        @(negedge clk); #2;
        chk_out("ar_before", 5'b00000, 3'b001);
        chk_cnt("ar_before_cnt", 2, 0, 0);
        rst_n = 0; #1;
        chk_out("ar_after", 5'b00000, 3'b000);
        chk_cnt("ar_after_cnt", 0, 0, 0);
        @(negedge clk); idle(); rst_n = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); set_load_use();
            @(posedge clk); #1;
            chk_cnt($sformatf("sat%0d", i), (i >= 14) ? 4'd15 : 4'(i + 1), 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk); set_load_use(); #1;
        chk_out("b2b_lu", 5'b00111, 3'b010);
        @(negedge clk); hz.ex_branch_taken = 1; #1;
        chk_out("b2b_br", 5'b11111, 3'b110);
        @(negedge clk); idle(); hz.ex_branch_taken = 1; #1;
        chk_out("b2b_br2", 5'b11111, 3'b110);
        @(negedge clk); idle(); #1;
        chk_out("b2b_idle", 5'b11111, 3'b000);
        chk_cnt("b2b_cnt", 1, 2, 0);
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
